// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int MEM_ADDR_WIDTH  = 8;
  localparam int MEM_WAIT_CYCLES = 2;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, write-first, registered read data.
module mem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata <= we ? wdata : mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Req/ack memory responder with programmable wait states
// and misaligned / out-of-range error reporting.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic capture;

  logic                  we_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic bad, resp, zero_q;
  logic ram_re, ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign bad = (|addr_q[1:0])
             | (|(addr_q >> (ADDR_WIDTH + 2)));
  assign resp = (state == RESP);

  // Reset gates the RAM so a dropped access never lands.
  assign ram_we = resp & reset & we_q & ~bad;
  assign ram_re = resp & reset & ~we_q & ~bad;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
          end else begin
            state_nx = BUSY;
            cnt_nx   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0)
          state_nx = RESP;
        else
          cnt_nx = cnt - 4'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      ack    <= 1'b0;
      err    <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ack   <= resp;
      err   <= resp & bad;
      if (resp & bad)
        zero_q <= 1'b1;
      else if (ram_re)
        zero_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Read data lives in the RAM output register; zero_q masks it
  // after reset or an error response.
  assign rdata = zero_q ? '0 : ram_rdata;

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .re   (ram_re),
    .we   (ram_we),
    .addr (addr_q[ADDR_WIDTH+1:2]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

endmodule
